// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: T-flip-flop counter sequenced by an IDLE/RUN/PAUSE/DONE FSM with a config handshake.
// Define CNT_PRESCALE_EN to add the cfg_presc input and an advance prescaler.
module cnt_seq_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_mode,
`ifdef CNT_PRESCALE_EN
   input  logic [3:0]       cfg_presc,
`endif
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] limit, q_nx, tog;
   logic mode, tc_nx, hs, adv, go;
   assign cfg_ready = (state == IDLE) || (state == DONE);
   assign busy = (state == RUN) || (state == PAUSE);
   assign done = (state == DONE);
   assign hs = cfg_valid && cfg_ready;
   // each stage toggles only when every lower stage is 1
   for (genvar i = 0; i < WIDTH; i++) begin : g_t
      if (i == 0) begin : g_b0
         assign tog[i] = 1'b1;
      end else begin : g_bi
         assign tog[i] = &q[i-1:0];
      end
   end
`ifdef CNT_PRESCALE_EN
   logic [3:0] presc, pcnt, pcnt_nx;
   assign adv = (pcnt == presc);
   assign pcnt_nx = go ? 4'd0 : (state == RUN && !stop) ? (adv ? 4'd0 : pcnt + 4'd1) : pcnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= 4'd0;
         pcnt <= 4'd0;
      end else begin
         pcnt <= pcnt_nx;
         if (hs) presc <= cfg_presc;
      end
   end
`else
   assign adv = 1'b1;
`endif
   always_comb begin
      state_nx = state;
      q_nx = q;
      tc_nx = 1'b0;
      go = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (hs) q_nx = '0;
            if (stop) begin
               state_nx = IDLE;
               q_nx = '0;
            end else if (start) begin
               state_nx = RUN;
               q_nx = '0;
               go = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = PAUSE;
            end else if (adv) begin
               if (q != limit) begin
                  q_nx = q ^ tog;
               end else begin
                  tc_nx = 1'b1;
                  q_nx = mode ? '0 : q;
                  state_nx = mode ? RUN : DONE;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               state_nx = IDLE;
               q_nx = '0;
            end else if (start) begin
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         q <= '0;
         limit <= '1;
         mode <= 1'b1;
         tc <= 1'b0;
      end else begin
         state <= state_nx;
         q <= q_nx;
         tc <= tc_nx;
         if (hs) begin
            limit <= cfg_limit;
            mode <= cfg_mode;
         end
      end
   end
endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the counter width in bits; legal range 1..16.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 cfg_valid  input  1  SHALL indicate that a configuration is offered.
REQ-005 cfg_ready  output  1  SHALL indicate that a configuration can be accepted; high in IDLE and DONE only.
REQ-006 cfg_limit  input  WIDTH  SHALL give the terminal count.
REQ-007 cfg_mode  input  1  SHALL select the mode: 0 = one-shot, 1 = auto-reload.
REQ-008 start  input  1  SHALL request that counting starts or resumes.
REQ-009 stop  input  1  SHALL request a pause, or an abort when already paused or done.
REQ-010 q  output  WIDTH  SHALL present the registered count value.
REQ-011 tc  output  1  SHALL be the registered terminal-count pulse.
REQ-012 busy  output  1  SHALL be high in RUN and PAUSE.
REQ-013 done  output  1  SHALL be high in DONE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-015 A configuration handshake SHALL occur when cfg_valid and cfg_ready are both high at an edge; that edge SHALL latch limit and mode and clear q to 0.
REQ-016 cfg_valid while cfg_ready is low SHALL be ignored, with no latch and no state change.
REQ-017 The count SHALL be built as T-flip-flop stages: bit 0 toggles on every advance; bit i toggles on an advance only when bits 0..i-1 are all 1.
REQ-018 IDLE + start: the next state SHALL be RUN and q SHALL stay 0 on that edge.
REQ-019 RUN: at each advance edge, if q != limit then q SHALL become q+1; if q == limit, see REQ-020 and REQ-021.
REQ-020 RUN, q == limit, mode 0: the next state SHALL be DONE, q SHALL hold limit, and tc SHALL be high for exactly the following cycle.
REQ-021 RUN, q == limit, mode 1: q SHALL become 0, the state SHALL stay RUN, and tc SHALL be high for exactly the following cycle.
REQ-022 limit 0 SHALL behave as follows: mode 0 goes to DONE at the first RUN edge; mode 1 keeps q at 0 with tc high every RUN cycle after the first.
REQ-023 RUN + stop SHALL go to PAUSE with q held; PAUSE + start SHALL return to RUN with counting resumed from the held q.
REQ-024 PAUSE + stop, or DONE + stop, SHALL go to IDLE with q cleared to 0.
REQ-025 DONE + start SHALL go to RUN with q cleared to 0 on that edge.
REQ-026 If start and stop are high in the same cycle, stop SHALL win.
REQ-027 A configuration handshake together with start in the same cycle in IDLE or DONE SHALL latch the new configuration and enter RUN with q = 0.
REQ-028 tc SHALL be 0 in all cycles except those defined in REQ-020 to REQ-022.

Reset
REQ-029 While rst is low, regardless of clk, the block SHALL hold: state IDLE, q = 0, limit = 2^WIDTH-1, mode = 1, tc = 0, busy = 0, done = 0, and cfg_ready = 1.
REQ-030 Reset asserted mid-RUN or mid-PAUSE SHALL abort immediately, with no tc generated.
REQ-031 After rst rises, the first edge SHALL be treated as a normal IDLE cycle.

Configuration
REQ-032 The macro CNT_PRESCALE_EN SHALL control the prescaler feature.
REQ-033 When CNT_PRESCALE_EN is defined:
- an input cfg_presc (4 bits) SHALL exist and SHALL be latched with each configuration handshake (reset value 0);
- in RUN, an advance SHALL occur only when an internal prescale counter equals presc, after which that counter returns to 0;
- the prescale counter SHALL clear on entry to RUN from IDLE or DONE, and SHALL hold in PAUSE.
REQ-034 When CNT_PRESCALE_EN is undefined, there SHALL be no cfg_presc port and every RUN edge SHALL be an advance.

Verification (WIDTH=3, macro undefined unless noted)
REQ-035 Reset, then start with the default configuration -> q goes 0,1,...,7,0,1; tc is high in the cycle where q first returns to 0; busy = 1.
REQ-036 Configure limit 5, mode 0, then start -> q goes 0..5 and holds at 5; done = 1; tc pulses once; a second start restarts from 0.
REQ-037 Stop at q = 3, wait 4 cycles, then start -> q holds at 3 in PAUSE, then continues 4,5...; stop twice -> IDLE with q = 0.
REQ-038 cfg_valid during RUN with limit 2 -> cfg_ready = 0 and the count continues to the old limit; start and stop together in IDLE -> the block stays in IDLE.
REQ-039 rst pulsed low at q = 6 in RUN -> q = 0 and IDLE immediately, with no tc.
REQ-040 With CNT_PRESCALE_EN defined, presc 2, limit 3, mode 1 -> q advances every 3 cycles; tc pulses once every 12 cycles.
